// File: rtl/rv_lsu_pkg.sv
// Shared types for the rv32 load/store unit: FSM states, bus encodings,
// funct3 codes and the legality/alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} lsu_state_e;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} tsize_e;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] doubles as the access size, so alignment keys off it alone.
    function automatic logic op_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] alo);
        logic f3_ok;
        logic al_ok;
        if (we)
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        case (f3[1:0])
            2'b01:   al_ok = ~alo[0];
            2'b10:   al_ok = (alo == 2'b00);
            default: al_ok = 1'b1;
        endcase
        return f3_ok && al_ok;
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Data bus between the LSU (master) and the memory slave.
interface master_bus_if;
    import lsu_pkg::*;

    logic        breq;
    logic        bstart;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;

    modport master(output breq, bstart, ttype, tsize, addr, wdata,
                   input  rdata, bdone);
    modport slave (input  breq, bstart, ttype, tsize, addr, wdata,
                   output rdata, bdone);

endinterface

// File: rtl/rv_lsu_align.sv
// Byte-lane steering: store data replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_in[{addr, 3'b000} +: 8];
    assign half_sel = rdata_in[{addr[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3[1:0])
            2'b00:   wdata_out = {4{wdata_in[7:0]}};
            2'b01:   wdata_out = {2{wdata_in[15:0]}};
            default: wdata_out = wdata_in;
        endcase
        case (funct3)
            F3_B:    rdata_out = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata_out = {{16{half_sel[15]}}, half_sel};
            F3_BU:   rdata_out = {24'd0, byte_sel};
            F3_HU:   rdata_out = {16'd0, half_sel};
            default: rdata_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one op from execute, runs the dbus transaction
// and returns extended load data (or an error) to writeback.
module rv_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic         rsp_err,
    master_bus_if.master dbus
);

    localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

    lsu_state_e  state;
    logic [2:0]  op_f3;
    logic [1:0]  op_alo;
    logic [15:0] to_cnt;
    logic [2:0]  al_f3;
    logic [1:0]  al_addr;
    logic [31:0] lane_wdata;
    logic [31:0] ext_rdata;
    logic        to_hit;

    // One aligner serves both directions: incoming request in IDLE, latched op afterwards.
    assign al_f3   = (state == IDLE) ? req_funct3 : op_f3;
    assign al_addr = (state == IDLE) ? req_addr[1:0] : op_alo;
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (({1'b0, to_cnt} + 17'd1) >= TO_LIM);

    lsu_align u_align (
        .funct3    (al_f3),
        .addr      (al_addr),
        .wdata_in  (req_wdata),
        .rdata_in  (dbus.rdata),
        .wdata_out (lane_wdata),
        .rdata_out (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            dbus.breq   <= 1'b0;
            dbus.bstart <= 1'b0;
            dbus.ttype  <= READ;
            dbus.tsize  <= WORD;
            dbus.addr   <= '0;
            dbus.wdata  <= '0;
            to_cnt      <= '0;
            op_f3       <= '0;
            op_alo      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_f3     <= req_funct3;
                    op_alo    <= req_addr[1:0];
                    req_ready <= 1'b0;
                    if (op_legal(req_we, req_funct3, req_addr[1:0])) begin
                        state       <= START;
                        dbus.breq   <= 1'b1;
                        dbus.bstart <= 1'b1;
                        dbus.ttype  <= req_we ? WRITE : READ;
                        dbus.tsize  <= tsize_e'(req_funct3[1:0]);
                        dbus.addr   <= req_addr;
                        dbus.wdata  <= lane_wdata;
                        to_cnt      <= '0;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                START: begin
                    state       <= WAIT;
                    dbus.bstart <= 1'b0;
                end
                WAIT: if (dbus.bdone) begin
                    state     <= RESP;
                    dbus.breq <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= (dbus.ttype == WRITE) ? 32'd0 : ext_rdata;
                end else if (to_hit) begin
                    state     <= RESP;
                    dbus.breq <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else if (to_cnt != 16'hFFFF) begin
                    to_cnt <= to_cnt + 16'd1;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu with a delay-programmable dbus slave model.
module tb_rv_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    master_bus_if bus();

    rv_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dbus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave: bdone pulses slave_delay cycles after the bstart cycle; 0 = never.
    int          slave_delay = 0;
    logic [31:0] slave_rdata = '0;
    int          timer = 0;
    always begin
        @(posedge clk);
        #1;
        bus.bdone = 1'b0;
        if (bus.bstart) begin
            timer = slave_delay;
        end else if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                bus.bdone = 1'b1;
                bus.rdata = slave_rdata;
            end
        end
    end

    int          breq_cnt, bstart_cnt, rsp_cnt;
    int          bstart_cyc, bdone_cyc, rsp_cyc, acc_cyc;
    logic [31:0] cap_addr, cap_wdata, r_rdata;
    logic [1:0]  cap_tsize;
    logic        cap_ttype, r_err;

    always @(negedge clk) begin
        if (bus.breq) breq_cnt++;
        if (bus.bstart) begin
            bstart_cnt++;
            bstart_cyc = cyc;
            cap_addr   = bus.addr;
            cap_wdata  = bus.wdata;
            cap_tsize  = bus.tsize;
            cap_ttype  = bus.ttype;
        end
        if (bus.bdone) bdone_cyc = cyc;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            r_rdata = rsp_rdata;
            r_err   = rsp_err;
        end
    end

    task automatic clr_mon();
        breq_cnt = 0; bstart_cnt = 0; rsp_cnt = 0;
        bstart_cyc = -1; bdone_cyc = -1; rsp_cyc = -1;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int dly);
        slave_delay = dly;
        slave_rdata = rd;
        clr_mon();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 40 && rsp_cnt == 0; i++) @(negedge clk);
        chk("rsp_seen", 32'(rsp_cnt != 0), 32'd1);
        @(posedge clk); #1;
        chk("rsp_once", rsp_cnt, 1);
    endtask

    task automatic chk_err_op(input string tag);
        chk({tag, "_nobreq"}, breq_cnt, 0);
        chk({tag, "_lat"}, rsp_cyc, acc_cyc + 1);
        chk({tag, "_err"}, r_err, 1);
        chk({tag, "_rd"}, r_rdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; bus.bdone = 1'b0; bus.rdata = '0;
        clr_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_breq", bus.breq, 0);
        chk("rst_bstart", bus.bstart, 0);
        chk("rst_ttype", bus.ttype, READ);
        chk("rst_tsize", bus.tsize, WORD);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk("lw_bstarts", bstart_cnt, 1);
        chk("lw_bstart_lat", bstart_cyc, acc_cyc + 1);
        chk("lw_bdone_cyc", bdone_cyc, acc_cyc + 3);
        chk("lw_rsp_lat", rsp_cyc, bdone_cyc + 1);
        chk("lw_rd", r_rdata, 32'hDEADBEEF);
        chk("lw_err", r_err, 0);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_tsize", cap_tsize, WORD);
        chk("lw_ttype", cap_ttype, READ);

        run_op(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF0011, 1);
        chk("lb_rd", r_rdata, 32'hFFFFFF80);
        run_op(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF0011, 3);
        chk("lbu_rd", r_rdata, 32'h00000080);
        run_op(1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF0011, 1);
        chk("lhu_rd", r_rdata, 32'h000080FF);
        chk("lhu_tsize", cap_tsize, HALF);
        run_op(1'b0, F3_H, 32'h102, 32'h0, 32'h80FF0011, 1);
        chk("lh_rd", r_rdata, 32'hFFFF80FF);

        run_op(1'b0, F3_W, 32'h102, 32'h0, 32'h0, 1);
        chk_err_op("lw_mis");

        run_op(1'b1, F3_B, 32'h201, 32'h12345678, 32'hFFFFFFFF, 1);
        chk("sb_wdata", cap_wdata, 32'h78787878);
        chk("sb_tsize", cap_tsize, BYTE);
        chk("sb_ttype", cap_ttype, WRITE);
        chk("sb_addr", cap_addr, 32'h201);
        chk("sb_rd", r_rdata, 0);
        chk("sb_err", r_err, 0);

        run_op(1'b1, F3_H, 32'h202, 32'hABCD1234, 32'hFFFFFFFF, 2);
        chk("sh_wdata", cap_wdata, 32'h12341234);
        chk("sh_tsize", cap_tsize, HALF);
        chk("sh_rd", r_rdata, 0);

        run_op(1'b1, F3_H, 32'h201, 32'h12345678, 32'h0, 1);
        chk_err_op("sh_mis");
        run_op(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1);
        chk_err_op("ld_f3_011");
        run_op(1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1);
        chk_err_op("st_f3_100");

        // Silent slave: START plus 8 WAIT cycles of breq, then error response.
        run_op(1'b0, F3_W, 32'h300, 32'h0, 32'h0, 0);
        chk("to_err", r_err, 1);
        chk("to_rd", r_rdata, 0);
        chk("to_breq_cycles", breq_cnt, 9);
        chk("to_lat", rsp_cyc, acc_cyc + 10);
        @(negedge clk);
        chk("to_breq_low", bus.breq, 0);
        @(posedge clk); #1;

        // Reset in the middle of WAIT drops the op.
        slave_delay = 0;
        clr_mon();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h400;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_pre_breq", bus.breq, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_breq", bus.breq, 0);
        chk("rstw_bstart", bus.bstart, 0);
        chk("rstw_ready", req_ready, 1);
        repeat (12) @(negedge clk);
        chk("rstw_no_rsp", rsp_cnt, 0);
        @(posedge clk); #1;

        run_op(1'b0, F3_W, 32'h100, 32'h0, 32'hCAFEF00D, 3);
        chk("post_rst_rd", r_rdata, 32'hCAFEF00D);
        chk("post_rst_lat", rsp_cyc, acc_cyc + 5);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
